// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: turns raw TMR pair-mismatch flags into confirmed faults,
// drives a resync req/ack handshake, latches a no-majority alarm and counts
// majority-voted command arrivals.
// Optional build macro: TMR_MON_STICKY_LOG_EN adds the err_sticky[2:0] log output.
module tmr_fault_monitor #(
  parameter int unsigned PERSIST     = 4,
  parameter int unsigned HOLDOFF     = 1024,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       trx_error,
  input  logic [2:0]       output_io_error,
  input  logic [2:0]       command_arrive_discrepancy,
  input  logic [2:0]       command_arrive,
  input  logic             resync_ack,
  input  logic             clear_fatal,
  output logic             resync_req,
  output logic [2:0]       fault_instance,
  output logic [CNT_W-1:0] fault_cnt_1,
  output logic [CNT_W-1:0] fault_cnt_2,
  output logic [CNT_W-1:0] fault_cnt_3,
  output logic [CNT_W-1:0] unclass_cnt,
  output logic [CNT_W-1:0] cmd_cnt,
  output logic             fatal
`ifdef TMR_MON_STICKY_LOG_EN
  ,
  output logic [2:0]       err_sticky
`endif
);

  localparam int unsigned PCNT_W = (PERSIST > 2) ? $clog2(PERSIST) : 1;
  localparam int unsigned HCNT_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned TCNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_MONITOR = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_RESYNC  = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_FATAL   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched pattern and the persistence / holdoff / ack-timeout counters
  logic [2:0]        pl_q, pl_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  // Next values of the registered outputs
  logic             resync_req_d;
  logic [2:0]       fault_instance_d;
  logic [CNT_W-1:0] fault_cnt_1_d;
  logic [CNT_W-1:0] fault_cnt_2_d;
  logic [CNT_W-1:0] fault_cnt_3_d;
  logic [CNT_W-1:0] unclass_cnt_d;
  logic             fatal_d;

  // Combined mismatch pattern and decoded conditions
  logic [2:0] pat_c;
  logic       confirm_c;
  logic       is_inst1_c;
  logic       is_inst2_c;
  logic       is_inst3_c;
  logic       is_single_c;
  logic       is_nomaj_c;
  logic       timeout_c;
  logic       hold_done_c;
  logic       cmd_vote_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Pattern decode; a pair is named by the two instances it disagrees across
  always_comb begin
    pat_c       = trx_error | output_io_error | command_arrive_discrepancy;
    confirm_c   = (state_q == ST_CONFIRM) && (pat_c == pl_q) &&
                  (pcnt_q == PCNT_W'(PERSIST - 1));
    is_inst1_c  = (pat_c == 3'b101);
    is_inst2_c  = (pat_c == 3'b011);
    is_inst3_c  = (pat_c == 3'b110);
    is_single_c = is_inst1_c | is_inst2_c | is_inst3_c;
    is_nomaj_c  = (pat_c == 3'b111);
    timeout_c   = (tcnt_q == TCNT_W'(ACK_TIMEOUT - 1));
    hold_done_c = (hcnt_q == HCNT_W'(HOLDOFF - 1));
    cmd_vote_c  = (command_arrive[0] & command_arrive[1]) |
                  (command_arrive[1] & command_arrive[2]) |
                  (command_arrive[0] & command_arrive[2]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_MONITOR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MONITOR: begin
        if (pat_c != 3'b000) state_d = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (pat_c == 3'b000) begin
          state_d = ST_MONITOR;
        end else if (confirm_c) begin
          if (is_single_c)     state_d = ST_RESYNC;
          else if (is_nomaj_c) state_d = ST_FATAL;
          else                 state_d = ST_HOLDOFF;
        end
      end
      ST_RESYNC: begin
        // A same-edge ack beats the timeout
        if (resync_ack)     state_d = ST_HOLDOFF;
        else if (timeout_c) state_d = ST_FATAL;
      end
      ST_HOLDOFF: begin
        if (hold_done_c) state_d = ST_MONITOR;
      end
      ST_FATAL: begin
        if (clear_fatal) state_d = ST_MONITOR;
      end
      default: state_d = ST_MONITOR;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    pl_d             = pl_q;
    pcnt_d           = pcnt_q;
    hcnt_d           = hcnt_q;
    tcnt_d           = tcnt_q;
    resync_req_d     = resync_req;
    fault_instance_d = fault_instance;
    fault_cnt_1_d    = fault_cnt_1;
    fault_cnt_2_d    = fault_cnt_2;
    fault_cnt_3_d    = fault_cnt_3;
    unclass_cnt_d    = unclass_cnt;
    fatal_d          = fatal;
    case (state_q)
      ST_MONITOR: begin
        if (pat_c != 3'b000) begin
          pl_d   = pat_c;
          pcnt_d = PCNT_W'(1);
        end
      end
      ST_CONFIRM: begin
        if (pat_c == 3'b000) begin
          pcnt_d = '0;
        end else if (pat_c != pl_q) begin
          pl_d   = pat_c;
          pcnt_d = PCNT_W'(1);
        end else if (!confirm_c) begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end else begin
          pcnt_d = '0;
          if (is_single_c) begin
            resync_req_d     = 1'b1;
            tcnt_d           = '0;
            fault_instance_d = {is_inst3_c, is_inst2_c, is_inst1_c};
            if (is_inst1_c) fault_cnt_1_d = sat_inc(fault_cnt_1);
            if (is_inst2_c) fault_cnt_2_d = sat_inc(fault_cnt_2);
            if (is_inst3_c) fault_cnt_3_d = sat_inc(fault_cnt_3);
          end else if (is_nomaj_c) begin
            fatal_d = 1'b1;
          end else begin
            unclass_cnt_d = sat_inc(unclass_cnt);
            hcnt_d        = '0;
          end
        end
      end
      ST_RESYNC: begin
        if (resync_ack) begin
          resync_req_d = 1'b0;
          hcnt_d       = '0;
        end else if (timeout_c) begin
          resync_req_d = 1'b0;
          fatal_d      = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (hold_done_c) begin
          fault_instance_d = 3'b000;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      ST_FATAL: begin
        resync_req_d = 1'b0;
        if (clear_fatal) begin
          fatal_d          = 1'b0;
          fault_instance_d = 3'b000;
        end
      end
      default: begin
        pcnt_d = '0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      pl_q           <= '0;
      pcnt_q         <= '0;
      hcnt_q         <= '0;
      tcnt_q         <= '0;
      resync_req     <= 1'b0;
      fault_instance <= 3'b000;
      fault_cnt_1    <= '0;
      fault_cnt_2    <= '0;
      fault_cnt_3    <= '0;
      unclass_cnt    <= '0;
      fatal          <= 1'b0;
    end else begin
      pl_q           <= pl_d;
      pcnt_q         <= pcnt_d;
      hcnt_q         <= hcnt_d;
      tcnt_q         <= tcnt_d;
      resync_req     <= resync_req_d;
      fault_instance <= fault_instance_d;
      fault_cnt_1    <= fault_cnt_1_d;
      fault_cnt_2    <= fault_cnt_2_d;
      fault_cnt_3    <= fault_cnt_3_d;
      unclass_cnt    <= unclass_cnt_d;
      fatal          <= fatal_d;
    end
  end

  // Majority-voted command counter, free-running and wrapping
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_cnt <= '0;
    end else if (cmd_vote_c) begin
      cmd_cnt <= cmd_cnt + CNT_W'(1);
    end
  end

`ifdef TMR_MON_STICKY_LOG_EN
  logic [2:0] sticky_set_c;

  // Per-group raw activity, no persistence filtering
  always_comb begin
    sticky_set_c = {|command_arrive_discrepancy, |output_io_error, |trx_error};
  end

  // Sticky log: set beats a same-cycle operator clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_sticky <= 3'b000;
    end else if (clear_fatal) begin
      err_sticky <= sticky_set_c;
    end else begin
      err_sticky <= err_sticky | sticky_set_c;
    end
  end
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Scoreboard bench for tmr_fault_monitor: stimulus pushes expected output
// snapshots, a negedge monitor pops and compares them against the DUT.
module tb_tmr_fault_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] trx_error, output_io_error, command_arrive_discrepancy, command_arrive;
  logic       resync_ack, clear_fatal;
  logic       resync_req, fatal;
  logic [2:0] fault_instance;
  logic [7:0] fault_cnt_1, fault_cnt_2, fault_cnt_3, unclass_cnt, cmd_cnt;
`ifdef TMR_MON_STICKY_LOG_EN
  logic [2:0] err_sticky;
  logic [2:0] s_err_sticky;
`endif

  // Second instance with a short holdoff for the saturation run
  logic [2:0] s_trx, s_zero3;
  logic       s_ack, s_zero1;
  logic       s_resync_req, s_fatal;
  logic [2:0] s_fault_instance;
  logic [7:0] s_fc1, s_fc2, s_fc3, s_unc, s_cmd;

  tmr_fault_monitor dut (
    .clk(clk), .rst(rst),
    .trx_error(trx_error), .output_io_error(output_io_error),
    .command_arrive_discrepancy(command_arrive_discrepancy),
    .command_arrive(command_arrive),
    .resync_ack(resync_ack), .clear_fatal(clear_fatal),
    .resync_req(resync_req), .fault_instance(fault_instance),
    .fault_cnt_1(fault_cnt_1), .fault_cnt_2(fault_cnt_2), .fault_cnt_3(fault_cnt_3),
    .unclass_cnt(unclass_cnt), .cmd_cnt(cmd_cnt), .fatal(fatal)
`ifdef TMR_MON_STICKY_LOG_EN
    , .err_sticky(err_sticky)
`endif
  );

  tmr_fault_monitor #(.PERSIST(4), .HOLDOFF(8), .ACK_TIMEOUT(256), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst),
    .trx_error(s_trx), .output_io_error(s_zero3),
    .command_arrive_discrepancy(s_zero3),
    .command_arrive(s_zero3),
    .resync_ack(s_ack), .clear_fatal(s_zero1),
    .resync_req(s_resync_req), .fault_instance(s_fault_instance),
    .fault_cnt_1(s_fc1), .fault_cnt_2(s_fc2), .fault_cnt_3(s_fc3),
    .unclass_cnt(s_unc), .cmd_cnt(s_cmd), .fatal(s_fatal)
`ifdef TMR_MON_STICKY_LOG_EN
    , .err_sticky(s_err_sticky)
`endif
  );

  typedef struct packed {
    logic        sel;
    logic [44:0] vec;
    logic        chk_st;
    logic [2:0]  st;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passed = 0;

  // Expected-value model, updated by hand alongside the stimulus
  logic       e_req, e_fatal;
  logic [2:0] e_fi, e_st;
  logic [7:0] e_fc1, e_fc2, e_fc3, e_unc, e_cmd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic sel, input logic chk_st, input string nm);
    exp_t e;
    e.sel    = sel;
    e.vec    = {e_req, e_fi, e_fc1, e_fc2, e_fc3, e_unc, e_cmd, e_fatal};
    e.chk_st = chk_st;
    e.st     = e_st;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic zero_model();
    e_req = 0; e_fatal = 0; e_fi = 0; e_st = 0;
    e_fc1 = 0; e_fc2 = 0; e_fc3 = 0; e_unc = 0; e_cmd = 0;
  endtask

  // Monitor: drains the scoreboard on each falling edge
  initial begin
    exp_t        e;
    string       nm;
    logic [44:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.sel)
          act = {s_resync_req, s_fault_instance, s_fc1, s_fc2, s_fc3, s_unc, s_cmd, s_fatal};
        else
          act = {resync_req, fault_instance, fault_cnt_1, fault_cnt_2, fault_cnt_3,
                 unclass_cnt, cmd_cnt, fatal};
        checks++;
        if (act === e.vec) passed++;
        else $display("FAIL %s: {req,fi,fc1,fc2,fc3,unc,cmd,fatal} got %h want %h", nm, act, e.vec);
`ifdef TMR_MON_STICKY_LOG_EN
        if (e.chk_st) begin
          checks++;
          if (err_sticky === e.st) passed++;
          else $display("FAIL %s sticky: got %b want %b", nm, err_sticky, e.st);
        end
`endif
      end
    end
  end

  initial begin
    rst = 0; trx_error = 0; output_io_error = 0; command_arrive_discrepancy = 0;
    command_arrive = 0; resync_ack = 0; clear_fatal = 0;
    s_trx = 0; s_ack = 0; s_zero3 = 0; s_zero1 = 0;
    zero_model();
    tick(2);
    push_exp(0, 0, "reset_main");
    push_exp(1, 0, "reset_sat");
    rst = 1;
    tick(1);

    // 1: inst1 fault on output_io, ack after three cycles, holdoff
    output_io_error = 3'b101;
    tick(3);
    push_exp(0, 0, "t1_not_yet_confirmed");
    tick(1);
    e_req = 1; e_fi = 3'b001; e_fc1 = 1;
    push_exp(0, 0, "t1_confirm_inst1");
    output_io_error = 0;
    tick(2);
    push_exp(0, 0, "t1_req_held");
    resync_ack = 1;
    tick(1);
    resync_ack = 0;
    e_req = 0;
    push_exp(0, 0, "t1_ack_drops_req");
    trx_error = 3'b101;
    tick(10);
    trx_error = 0;
    tick(1013);
    push_exp(0, 0, "t1_holdoff_last_cycle");
    tick(1);
    e_fi = 0;
    push_exp(0, 0, "t1_holdoff_exit");

    // 2: short bursts and changing patterns never confirm
    trx_error = 3'b011; tick(3);
    trx_error = 0;      tick(1);
    push_exp(0, 0, "t2_short_burst");
    trx_error = 3'b110; tick(3);
    trx_error = 3'b011; tick(3);
    trx_error = 0;      tick(1);
    push_exp(0, 0, "t2_pattern_change");
    resync_ack = 1; tick(1); resync_ack = 0; tick(1);
    push_exp(0, 0, "t2_stray_ack");

    // 3: no majority goes fatal, counters frozen, operator clear
    command_arrive_discrepancy = 3'b111;
    tick(3);
    push_exp(0, 0, "t3_pre_fatal");
    tick(1);
    command_arrive_discrepancy = 0;
    e_fatal = 1;
    push_exp(0, 0, "t3_fatal_set");
    output_io_error = 3'b101; tick(6); output_io_error = 0;
    resync_ack = 1; tick(1); resync_ack = 0;
    push_exp(0, 0, "t3_frozen");
    clear_fatal = 1; tick(1); clear_fatal = 0;
    e_fatal = 0;
    push_exp(0, 0, "t3_cleared");
    trx_error = 3'b001; tick(4); trx_error = 0;
    e_unc = 1;
    push_exp(0, 0, "t3_unclassified");
    tick(1024);
    push_exp(0, 0, "t3_unclass_holdoff_done");

    // 4a: inst3 fault with no ack times out into FATAL
    trx_error = 3'b110; tick(4); trx_error = 0;
    e_req = 1; e_fi = 3'b100; e_fc3 = 1;
    push_exp(0, 0, "t4_confirm_inst3");
    tick(255);
    push_exp(0, 0, "t4_before_timeout");
    tick(1);
    e_req = 0; e_fatal = 1;
    push_exp(0, 0, "t4_timeout_fatal");
    clear_fatal = 1; tick(1); clear_fatal = 0;
    e_fatal = 0; e_fi = 0;
    push_exp(0, 0, "t4_clear");

    // 4b: ack on the timeout edge wins
    trx_error = 3'b110; tick(4); trx_error = 0;
    e_req = 1; e_fi = 3'b100; e_fc3 = 2;
    push_exp(0, 0, "t4b_confirm_inst3");
    tick(255);
    resync_ack = 1; tick(1); resync_ack = 0;
    e_req = 0;
    push_exp(0, 0, "t4b_ack_at_timeout");
    tick(1024);
    e_fi = 0;
    push_exp(0, 0, "t4b_holdoff_done");

    // 5: majority-voted command counting and wrap
    command_arrive = 3'b111; tick(1);
    command_arrive = 3'b110; tick(1);
    command_arrive = 3'b100; tick(1);
    command_arrive = 3'b011; tick(1);
    command_arrive = 0;
    e_cmd = 3;
    push_exp(0, 0, "t5_vote_seq");
    command_arrive = 3'b111; tick(252);
    e_cmd = 255;
    push_exp(0, 0, "t5_cmd_255");
    tick(1);
    command_arrive = 0;
    e_cmd = 0;
    push_exp(0, 0, "t5_cmd_wrap");

    // 6: reset in the middle of RESYNC
    trx_error = 3'b101; tick(4); trx_error = 0;
    e_req = 1; e_fi = 3'b001; e_fc1 = 2;
    push_exp(0, 0, "t6_confirm_inst1");
    command_arrive = 3'b111; tick(5); command_arrive = 0;
    e_cmd = 5;
    push_exp(0, 0, "t6_in_resync");
    rst = 0; tick(1); rst = 1;
    zero_model();
    push_exp(0, 1, "t6_reset");
`ifdef TMR_MON_STICKY_LOG_EN
    trx_error = 3'b001; tick(1); trx_error = 0;
    e_st = 3'b001;
    push_exp(0, 1, "t6_sticky_set");
    tick(3);
    push_exp(0, 1, "t6_sticky_hold");
    clear_fatal = 1; tick(1); clear_fatal = 0;
    e_st = 3'b000;
    push_exp(0, 1, "t6_sticky_clear");
    output_io_error = 3'b010; clear_fatal = 1; tick(1);
    output_io_error = 0; clear_fatal = 0;
    e_st = 3'b010;
    push_exp(0, 1, "t6_sticky_set_wins");
    tick(2);
    clear_fatal = 1; tick(1); clear_fatal = 0;
    e_st = 3'b000;
    push_exp(0, 1, "t6_sticky_clear2");
`endif
    trx_error = 3'b101; tick(4); trx_error = 0;
    e_req = 1; e_fi = 3'b001; e_fc1 = 1;
`ifdef TMR_MON_STICKY_LOG_EN
    e_st = 3'b001;
`endif
    push_exp(0, 1, "t6_monitor_after_reset");

    // 5b: 256 confirmed inst2 faults saturate fault_cnt_2
    zero_model();
    for (int i = 0; i < 256; i++) begin
      s_trx = 3'b011; tick(4); s_trx = 0;
      if (i == 255) begin
        e_req = 1; e_fi = 3'b010; e_fc2 = 8'd255;
        push_exp(1, 0, "sat_confirm_256th");
      end
      s_ack = 1; tick(1); s_ack = 0;
      tick(8);
      if (i == 254) begin
        e_fc2 = 8'd255;
        push_exp(1, 0, "sat_255_faults");
      end
    end
    e_req = 0; e_fi = 0; e_fc2 = 8'd255;
    push_exp(1, 0, "sat_256_faults");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tmr_fault_monitor.md
Name: tmr_fault_monitor

Overview:
Consumes the TMR health signals from the triplicated GPIO/UART controller and turns raw pairwise mismatches into confirmed faults.
- Filters transient disagreement with a persistence window.
- Identifies the faulty instance and counts faults per instance.
- Requests a resynchronisation of the controller instances through a req/ack handshake.
- Latches a fatal alarm when no majority exists.
- Also counts majority-voted command arrivals.

Parameters:
PERSIST, 4, consecutive cycles (min 2) an identical non-zero mismatch pattern must hold to be confirmed
HOLDOFF, 1024, cycles mismatches are ignored after a resync or unclassified event
ACK_TIMEOUT, 256, max cycles in RESYNC waiting for resync_ack before going FATAL
CNT_W, 8, width of all saturating counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
trx_error  in  3  pair mismatch on tx: [0]=inst1/2, [1]=inst2/3, [2]=inst1/3
output_io_error  in  3  pair mismatch on output_io, same bit order
command_arrive_discrepancy  in  3  pair mismatch on command_valid, same bit order
command_arrive  in  3  raw command_valid pulses: [2]=inst1, [1]=inst2, [0]=inst3
resync_ack  in  1  controller has completed resync
clear_fatal  in  1  operator clear of fatal state
resync_req  out  1  resync request, level, held until ack
fault_instance  out  3  one-hot faulty instance: [0]=inst1, [1]=inst2, [2]=inst3
fault_cnt_1 / fault_cnt_2 / fault_cnt_3  out  CNT_W each  confirmed faults per instance, saturating
unclass_cnt  out  CNT_W  confirmed single-pair (unclassifiable) patterns, saturating
cmd_cnt  out  CNT_W  majority-voted commands, wraps
fatal  out  1  no-majority fault latched

Behaviour:
Reset and pattern:
- Reset (rst=0 at clk edge) has priority over everything.
- On reset: state=MONITOR, all outputs 0, all counters 0, persistence/holdoff/timeout counters 0.
- Pattern P = trx_error | output_io_error | command_arrive_discrepancy, evaluated every cycle.

Classification of a confirmed P:
- 3'b101 → inst1.
- 3'b011 → inst2.
- 3'b110 → inst3.
- 3'b111 → no majority.
- One bit set → unclassified.

FSM:
- MONITOR:
  - P!=0 → CONFIRM; latch Pl=P; pcnt=1.
- CONFIRM:
  - P==0 → MONITOR.
  - P!=Pl → relatch Pl=P, pcnt=1.
  - P==Pl and pcnt<PERSIST-1 → pcnt++.
  - P==Pl and pcnt==PERSIST-1 → confirm:
    - Single instance: increment its fault_cnt (saturate at all-ones); set fault_instance one-hot; resync_req=1 → RESYNC.
    - Unclassified: unclass_cnt++ (saturating) → HOLDOFF.
    - No majority: fatal=1 → FATAL.
  - Timing: P stable at edges k..k+PERSIST-1 gives outputs visible after edge k+PERSIST-1.
- RESYNC:
  - resync_req held at 1; tcnt increments each cycle.
  - resync_ack=1 sampled → resync_req=0 on that edge → HOLDOFF.
  - tcnt reaches ACK_TIMEOUT-1 without ack → resync_req=0, fatal=1 → FATAL.
  - Ack and timeout on the same edge: ack wins.
- HOLDOFF:
  - P ignored; hcnt counts to HOLDOFF-1.
  - Then → MONITOR; fault_instance cleared to 0 on that edge.
- FATAL:
  - fatal=1, resync_req=0; P ignored; counters frozen.
  - clear_fatal=1 → fatal=0, fault_instance=0 → MONITOR.
  - clear_fatal outside FATAL is ignored.

Command counting:
- cmd_cnt increments by 1 each cycle in which ≥2 bits of command_arrive are set.
- Counts in all states except reset; wraps modulo 2^CNT_W.
- Independent of the FSM.

Other rules:
- resync_ack outside RESYNC is ignored.
- Saturated counters stay at all-ones until reset.

Optional Feature:
TMR_MON_STICKY_LOG_EN
- Defined: adds output err_sticky[2:0] = {cmd, out_io, trx}.
  - A bit sets on any cycle its group's input is non-zero, persistence not required.
  - Cleared only by reset or clear_fatal (any state); set wins over same-cycle clear.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. output_io_error=3'b101 held 4 cycles → resync_req=1 and fault_instance=3'b001 after 4th edge, fault_cnt_1=1; ack 3 cycles later → resync_req=0, HOLDOFF 1024 cycles, then fault_instance=0.
2. trx_error=3'b011 for 3 cycles then 0 → no confirm, all counters 0, state back to MONITOR; then 3'b110 for 3 cycles and 3'b011 for 3 cycles → no confirm (pattern change restarts pcnt).
3. Discrepancy 3'b111 held 4 cycles → fatal=1; further mismatches do not change counters; clear_fatal pulse → fatal=0, MONITOR.
4. Confirm inst3 fault, never ack → after 256 cycles in RESYNC resync_req=0, fatal=1; separately, ack on the timeout edge → HOLDOFF, fatal=0.
5. command_arrive sequence 3'b111, 3'b110, 3'b100, 3'b011 over four cycles → cmd_cnt=3; force 256 valid commands from 0 → cmd_cnt wraps to 0; 256 confirmed inst2 faults → fault_cnt_2 stays 255.
6. Assert rst=0 mid-RESYNC with resync_req=1 → next edge all outputs 0, state MONITOR; with TMR_MON_STICKY_LOG_EN, a 1-cycle trx_error=3'b001 → err_sticky=3'b001 until clear_fatal.
